// File: rtl/ysyx_22051013_axi_arbiter_rr_if.sv
// AXI4 master-side bundle (AR/R/AW/W/B) shared by the round-robin read arbiter and the write path.
// The master modport is the arbiter view; the slave modport is the memory/interconnect view.
interface ysyx_22051013_axi_arbiter_rr_if #(
  parameter int AW  = 64,
  parameter int DW  = 64,
  parameter int IDW = 4
) ();

  logic [IDW-1:0]  arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [IDW-1:0]  rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [IDW-1:0]  awid;
  logic [AW-1:0]   awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/ysyx_22051013_axi_arbiter_rr.sv
// Round-robin arbiter of NREQ read requesters onto one AXI read port, plus an
// independent single-requester write path; the two FSMs run concurrently.
module ysyx_22051013_axi_arbiter_rr #(
  parameter int NREQ = 2,
  parameter int AW   = 64,
  parameter int DW   = 64,
  parameter int IDW  = 4,
  parameter int WID  = NREQ
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [NREQ-1:0]      rd_req,
  input  logic [NREQ*AW-1:0]   rd_addr,
  input  logic [NREQ*3-1:0]    rd_size,
  input  logic [NREQ*8-1:0]    rd_len,
  output logic [DW-1:0]        rd_data,
  output logic [NREQ-1:0]      rd_beat_valid,
  output logic [NREQ-1:0]      rd_done,
  output logic [NREQ-1:0]      rd_err,

  input  logic                 wr_req,
  input  logic [AW-1:0]        wr_addr,
  input  logic [2:0]           wr_size,
  input  logic [7:0]           wr_len,
  input  logic [DW-1:0]        wr_data,
  input  logic [DW/8-1:0]      wr_strb,
  output logic                 wr_beat_ready,
  output logic                 wr_done,
  output logic                 wr_err,

  ysyx_22051013_axi_arbiter_rr_if.master axi
);

  localparam int         PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_e;

  // First requester at or after start, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                            input logic [PW-1:0]   start);
    int            idx;
    logic [PW-1:0] ix;
    logic [PW-1:0] pick;
    logic          hit;
    pick = start;
    hit  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      ix = PW'(idx);
      if (!hit && req[ix]) begin
        pick = ix;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] g);
    if (g == PW'(NREQ - 1)) return '0;
    return g + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // ---------------------------------------------------------------- read path
  rstate_e          r_state, r_next;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grant;
  logic [PW-1:0]    gnt_sel;
  logic             err_acc;
  logic [AW-1:0]    ar_addr_q;
  logic [7:0]       ar_len_q;
  logic [2:0]       ar_size_q;
  logic [AW-1:0]    sel_addr;
  logic [7:0]       sel_len;
  logic [2:0]       sel_size;
  logic             r_take;
  logic             ar_hs;
  logic             r_hs;
  logic             r_match;
  logic             r_last_match;
  logic             r_beat_err;

  assign gnt_sel = rr_pick(rd_req, ptr);
  assign r_take  = (r_state == R_IDLE) && (|rd_req);

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_size = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_sel == PW'(i)) begin
        sel_addr = rd_addr[i*AW +: AW];
        sel_len  = rd_len[i*8 +: 8];
        sel_size = rd_size[i*3 +: 3];
      end
    end
  end

  assign axi.arvalid = (r_state == R_ADDR);
  assign axi.arid    = IDW'(grant);
  assign axi.araddr  = ar_addr_q;
  assign axi.arlen   = ar_len_q;
  assign axi.arsize  = ar_size_q;
  assign axi.arburst = BURST_INCR;
  assign axi.rready  = (r_state == R_DATA);

  assign ar_hs        = axi.arvalid && axi.arready;
  assign r_hs         = axi.rvalid && axi.rready;
  // Beats tagged for another ID are still accepted (rready high) but dropped.
  assign r_match      = r_hs && (axi.rid == IDW'(grant));
  assign r_last_match = r_match && axi.rlast;
  assign r_beat_err   = (axi.rresp != 2'b00);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (|rd_req)      r_next = R_ADDR;
      R_ADDR:  if (ar_hs)        r_next = R_DATA;
      R_DATA:  if (r_last_match) r_next = R_IDLE;
      default:                   r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      grant   <= '0;
      err_acc <= 1'b0;
    end else if (r_take) begin
      grant   <= gnt_sel;
      ptr     <= wrap_inc(gnt_sel);
      err_acc <= 1'b0;
    end else if (r_match) begin
      err_acc <= axi.rlast ? 1'b0 : (err_acc | r_beat_err);
    end
  end

  // Request fields are captured once per grant; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (r_take) begin
      ar_addr_q <= sel_addr;
      ar_len_q  <= sel_len;
      ar_size_q <= sel_size;
    end
  end

  assign rd_data       = axi.rdata;
  assign rd_beat_valid = r_match      ? onehot(grant) : '0;
  assign rd_done       = r_last_match ? onehot(grant) : '0;
  assign rd_err        = (r_last_match && (err_acc || r_beat_err)) ? onehot(grant) : '0;

  // --------------------------------------------------------------- write path
  wstate_e          w_state, w_next;
  logic             aw_ok;
  logic             w_ok;
  logic [7:0]       w_cnt;
  logic [AW-1:0]    aw_addr_q;
  logic [7:0]       aw_len_q;
  logic [2:0]       aw_size_q;
  logic             w_take;
  logic             aw_hs;
  logic             w_hs;
  logic             aw_fin;
  logic             w_fin;
  logic             b_hs;
  logic             b_match;

  assign w_take = (w_state == W_IDLE) && wr_req;

  assign axi.awvalid = (w_state == W_XFER) && !aw_ok;
  assign axi.awid    = IDW'(WID);
  assign axi.awaddr  = aw_addr_q;
  assign axi.awlen   = aw_len_q;
  assign axi.awsize  = aw_size_q;
  assign axi.awburst = BURST_INCR;
  assign axi.wvalid  = (w_state == W_XFER) && !w_ok;
  assign axi.wdata   = wr_data;
  assign axi.wstrb   = wr_strb;
  assign axi.wlast   = (w_cnt == aw_len_q);
  assign axi.bready  = (w_state == W_RESP);

  assign aw_hs   = axi.awvalid && axi.awready;
  assign w_hs    = axi.wvalid && axi.wready;
  // AW and W complete in either order; each side is done once its flag or its handshake is seen.
  assign aw_fin  = aw_ok || aw_hs;
  assign w_fin   = w_ok || (w_hs && axi.wlast);
  assign b_hs    = axi.bvalid && axi.bready;
  assign b_match = b_hs && (axi.bid == IDW'(WID));

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_req)          w_next = W_XFER;
      W_XFER:  if (aw_fin && w_fin) w_next = W_RESP;
      W_RESP:  if (b_match)         w_next = W_IDLE;
      default:                      w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_ok <= 1'b0;
      w_ok  <= 1'b0;
      w_cnt <= '0;
    end else if (w_take) begin
      aw_ok <= 1'b0;
      w_ok  <= 1'b0;
      w_cnt <= '0;
    end else if (w_state == W_XFER) begin
      if (aw_hs) aw_ok <= 1'b1;
      if (w_hs) begin
        w_cnt <= w_cnt + 8'd1;
        if (axi.wlast) w_ok <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_take) begin
      aw_addr_q <= wr_addr;
      aw_len_q  <= wr_len;
      aw_size_q <= wr_size;
    end
  end

  assign wr_beat_ready = w_hs;
  assign wr_done       = b_match;
  assign wr_err        = b_match && (axi.bresp != 2'b00);

endmodule

// File: tb/tb_ysyx_22051013_axi_arbiter_rr.sv
// Scoreboard bench: directed stimulus queues the expected AXI requests and requester
// strobes; negedge monitors pop and compare whenever the DUT presents a handshake or strobe.
module tb_ysyx_22051013_axi_arbiter_rr;

  localparam int NREQ = 2;
  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int IDW  = 4;
  localparam int WID  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    rd_req;
  logic [NREQ*AW-1:0] rd_addr;
  logic [NREQ*3-1:0]  rd_size;
  logic [NREQ*8-1:0]  rd_len;
  logic [DW-1:0]      rd_data;
  logic [NREQ-1:0]    rd_beat_valid, rd_done, rd_err;
  logic               wr_req;
  logic [AW-1:0]      wr_addr;
  logic [2:0]         wr_size;
  logic [7:0]         wr_len;
  logic [DW-1:0]      wr_data;
  logic [DW/8-1:0]    wr_strb;
  logic               wr_beat_ready, wr_done, wr_err;

  ysyx_22051013_axi_arbiter_rr_if #(.AW(AW), .DW(DW), .IDW(IDW)) axi ();

  ysyx_22051013_axi_arbiter_rr #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW), .WID(WID)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_size(rd_size), .rd_len(rd_len),
    .rd_data(rd_data), .rd_beat_valid(rd_beat_valid), .rd_done(rd_done), .rd_err(rd_err),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_size(wr_size), .wr_len(wr_len),
    .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_beat_ready(wr_beat_ready), .wr_done(wr_done), .wr_err(wr_err),
    .axi(axi)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     len;
    logic [2:0]     size;
  } ax_t;
  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } rd_t;
  typedef struct {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            last;
  } w_t;

  ax_t  exp_ar[$];
  ax_t  exp_aw[$];
  rd_t  exp_rd[$];
  w_t   exp_w[$];
  logic exp_wr[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT presented an event with no expectation queued (t=%0t)", nm, $time);
  endtask

  function automatic logic [NREQ-1:0] oh(input int p);
    return NREQ'(1 << p);
  endfunction

  // ---------------- monitors
  always @(negedge clk) begin
    ax_t a;
    rd_t r;
    w_t  w;
    logic e;
    if (rst) begin
      if (axi.arvalid && axi.arready) begin
        if (exp_ar.size() == 0) unexpected("ar_handshake");
        else begin
          a = exp_ar.pop_front();
          chk("arid", 64'(axi.arid), 64'(a.id));
          chk("araddr", axi.araddr, a.addr);
          chk("arlen", 64'(axi.arlen), 64'(a.len));
          chk("arsize", 64'(axi.arsize), 64'(a.size));
          chk("arburst", 64'(axi.arburst), 64'd1);
        end
      end
      if (axi.awvalid && axi.awready) begin
        if (exp_aw.size() == 0) unexpected("aw_handshake");
        else begin
          a = exp_aw.pop_front();
          chk("awid", 64'(axi.awid), 64'(a.id));
          chk("awaddr", axi.awaddr, a.addr);
          chk("awlen", 64'(axi.awlen), 64'(a.len));
          chk("awsize", 64'(axi.awsize), 64'(a.size));
          chk("awburst", 64'(axi.awburst), 64'd1);
        end
      end
      if (axi.wvalid && axi.wready) begin
        if (exp_w.size() == 0) unexpected("w_beat");
        else begin
          w = exp_w.pop_front();
          chk("wdata", axi.wdata, w.data);
          chk("wstrb", 64'(axi.wstrb), 64'(w.strb));
          chk("wlast", 64'(axi.wlast), 64'(w.last));
          chk("wr_beat_ready", 64'(wr_beat_ready), 64'd1);
        end
      end
      if (|rd_beat_valid) begin
        if (exp_rd.size() == 0) unexpected("rd_beat_valid");
        else begin
          r = exp_rd.pop_front();
          chk("rd_beat_valid", 64'(rd_beat_valid), 64'(oh(r.port)));
          chk("rd_data", rd_data, r.data);
          chk("rd_done", 64'(rd_done), r.last ? 64'(oh(r.port)) : 64'd0);
          chk("rd_err", 64'(rd_err), (r.last && r.err) ? 64'(oh(r.port)) : 64'd0);
        end
      end else if ((|rd_done) || (|rd_err)) begin
        unexpected("rd_done_without_beat");
      end
      if (wr_done) begin
        if (exp_wr.size() == 0) unexpected("wr_done");
        else begin
          e = exp_wr.pop_front();
          chk("wr_err", 64'(wr_err), 64'(e));
        end
      end else if (wr_err) begin
        unexpected("wr_err_without_done");
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return axi.arvalid;
      1:       return axi.bready;
      default: return axi.rready;
    endcase
  endfunction

  task automatic wait_for(input int which, input string nm);
    int n;
    n = 0;
    while (!cond(which) && n < 100) begin
      step();
      n++;
    end
    if (!cond(which)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: actual=0 required=1 (t=%0t)", nm, $time);
    end
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s);
    rd_addr[p*AW +: AW] = a;
    rd_len[p*8 +: 8]    = l;
    rd_size[p*3 +: 3]   = s;
  endtask

  task automatic push_ar(input int id, input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s);
    ax_t x;
    x.id = IDW'(id); x.addr = a; x.len = l; x.size = s;
    exp_ar.push_back(x);
  endtask

  task automatic push_aw(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s);
    ax_t x;
    x.id = IDW'(WID); x.addr = a; x.len = l; x.size = s;
    exp_aw.push_back(x);
  endtask

  task automatic push_rd(input int p, input logic [DW-1:0] d, input logic last, input logic err);
    rd_t x;
    x.port = p; x.data = d; x.last = last; x.err = err;
    exp_rd.push_back(x);
  endtask

  task automatic push_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s, input logic last);
    w_t x;
    x.data = d; x.strb = s; x.last = last;
    exp_w.push_back(x);
  endtask

  task automatic ar_accept(input int delay);
    wait_for(0, "arvalid");
    repeat (delay) step();
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
  endtask

  task automatic r_beat(input int id, input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
    axi.rid    = IDW'(id);
    axi.rdata  = d;
    axi.rresp  = resp;
    axi.rlast  = last;
    axi.rvalid = 1'b1;
    step();
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_arvalid"}, 64'(axi.arvalid), 64'd0);
    chk({tag, "_awvalid"}, 64'(axi.awvalid), 64'd0);
    chk({tag, "_wvalid"}, 64'(axi.wvalid), 64'd0);
    chk({tag, "_rready"}, 64'(axi.rready), 64'd0);
    chk({tag, "_bready"}, 64'(axi.bready), 64'd0);
    chk({tag, "_rd_beat_valid"}, 64'(rd_beat_valid), 64'd0);
    chk({tag, "_rd_done"}, 64'(rd_done), 64'd0);
    chk({tag, "_rd_err"}, 64'(rd_err), 64'd0);
    chk({tag, "_wr_flags"}, 64'({wr_beat_ready, wr_done, wr_err}), 64'd0);
  endtask

  // ---------------- directed sequence
  initial begin
    int beat, wl_c, aw_c;
    logic hw, ha, lw, wdone, adone;

    rd_req = '0; rd_addr = '0; rd_size = '0; rd_len = '0;
    wr_req = 1'b0; wr_addr = '0; wr_size = '0; wr_len = '0; wr_data = '0; wr_strb = '0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
    axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;

    // Reset state, with requests already pending.
    rd_req = 2'b11; wr_req = 1'b1;
    step(); step();
    #2;
    check_quiet("reset");
    rd_req = '0; wr_req = 1'b0;
    step();
    rst = 1'b1;
    step();

    // Round robin with both ports requesting: 0,1,0,1.
    set_port(0, 64'h1000, 8'd0, 3'd3);
    set_port(1, 64'h2000, 8'd1, 3'd3);
    rd_req = 2'b11;
    for (int b = 0; b < 4; b++) begin
      int p;
      int l;
      p = b % 2;
      l = (p == 0) ? 0 : 1;
      push_ar(p, (p == 0) ? 64'h1000 : 64'h2000, 8'(l), 3'd3);
      ar_accept(b % 3);
      if (b == 3) rd_req = '0;
      for (int i = 0; i <= l; i++) begin
        push_rd(p, 64'hB000 + 64'(b * 16 + i), (i == l), 1'b0);
        r_beat(p, 64'hB000 + 64'(b * 16 + i), 2'b00, (i == l));
      end
    end
    step();

    // Port 1, four beats, error only on the last; inputs changed after grant are ignored.
    set_port(1, 64'h2_0000, 8'd3, 3'd2);
    rd_req = 2'b10;
    push_ar(1, 64'h2_0000, 8'd3, 3'd2);
    wait_for(0, "arvalid_p1");
    set_port(1, 64'hDEAD, 8'd7, 3'd1);
    rd_req = '0;
    ar_accept(2);
    for (int i = 0; i < 4; i++) begin
      push_rd(1, 64'hC000 + 64'(i), (i == 3), (i == 3));
      r_beat(1, 64'hC000 + 64'(i), (i == 3) ? 2'b10 : 2'b00, (i == 3));
    end
    step();

    // Stray beat with foreign rid while port 0 is granted.
    set_port(0, 64'h1000, 8'd1, 3'd3);
    rd_req = 2'b01;
    push_ar(0, 64'h1000, 8'd1, 3'd3);
    ar_accept(1);
    rd_req = '0;
    r_beat(5, 64'hBAD, 2'b00, 1'b1);
    #2;
    chk("stray_stays_in_r_data", 64'(axi.rready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      push_rd(0, 64'hA000 + 64'(i), (i == 1), 1'b0);
      r_beat(0, 64'hA000 + 64'(i), 2'b00, (i == 1));
    end
    step();

    // Write of two beats; AW held off three cycles so W completes first.
    wr_addr = 64'h8000; wr_len = 8'd1; wr_size = 3'd3; wr_strb = 8'hF0;
    wr_data = 64'hD000;
    push_aw(64'h8000, 8'd1, 3'd3);
    push_w(64'hD000, 8'hF0, 1'b0);
    push_w(64'hD001, 8'hF0, 1'b1);
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    axi.wready = 1'b1;
    beat = 0; wl_c = -1; aw_c = -1; wdone = 1'b0; adone = 1'b0;
    for (int c = 0; c < 30; c++) begin
      axi.awready = (c >= 3);
      #3;
      hw = wr_beat_ready;
      ha = axi.awvalid && axi.awready;
      lw = axi.wlast;
      step();
      if (hw) begin
        beat++;
        wr_data = 64'hD000 + 64'(beat);
        if (lw) begin wdone = 1'b1; wl_c = c; end
      end
      if (ha) begin adone = 1'b1; aw_c = c; end
      if (wdone && adone) break;
    end
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    chk("write_both_channels_done", 64'({wdone, adone}), 64'b11);
    chk("w_finishes_before_aw", 64'(wl_c < aw_c), 64'd1);
    wait_for(1, "bready");
    axi.bid = 4'd7; axi.bresp = 2'b00; axi.bvalid = 1'b1;
    step();
    push_wr_blk: begin
      exp_wr.push_back(1'b0);
    end
    axi.bid = IDW'(WID);
    step();
    axi.bvalid = 1'b0;
    #2;
    chk("bready_low_after_b", 64'(axi.bready), 64'd0);
    step();

    // Concurrent read (port 0, wrap from ptr=1) and write; R last and B in the same cycle.
    set_port(0, 64'h3000, 8'd1, 3'd3);
    wr_addr = 64'h9000; wr_len = 8'd0; wr_size = 3'd3; wr_strb = 8'hFF; wr_data = 64'hE0;
    push_ar(0, 64'h3000, 8'd1, 3'd3);
    push_aw(64'h9000, 8'd0, 3'd3);
    push_w(64'hE0, 8'hFF, 1'b1);
    push_rd(0, 64'h5000, 1'b0, 1'b0);
    push_rd(0, 64'h5001, 1'b1, 1'b0);
    exp_wr.push_back(1'b1);
    rd_req = 2'b01; wr_req = 1'b1;
    step();
    rd_req = '0; wr_req = 1'b0;
    axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
    step();
    axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
    axi.rid = '0; axi.rdata = 64'h5000; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b1;
    step();
    axi.rdata = 64'h5001; axi.rlast = 1'b1;
    axi.bid = IDW'(WID); axi.bresp = 2'b10; axi.bvalid = 1'b1;
    #2;
    chk("concurrent_rd_done0_and_wr_done", 64'({rd_done[0], wr_done}), 64'b11);
    step();
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.bvalid = 1'b0;
    step();

    // Reset during beat 2 of 4 (port 0 granted, ptr left at 1).
    set_port(0, 64'h4000, 8'd3, 3'd3);
    rd_req = 2'b01;
    push_ar(0, 64'h4000, 8'd3, 3'd3);
    ar_accept(0);
    rd_req = '0;
    push_rd(0, 64'hF000, 1'b0, 1'b0);
    r_beat(0, 64'hF000, 2'b11, 1'b0);
    axi.rid = '0; axi.rdata = 64'hF001; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b1;
    rst = 1'b0;
    #2;
    check_quiet("midburst_reset");
    step(); step();
    axi.rvalid = 1'b0;
    rst = 1'b1;
    step();
    rd_req = 2'b11;
    push_ar(0, 64'h4000, 8'd3, 3'd3);
    ar_accept(0);
    rd_req = '0;
    for (int i = 0; i < 4; i++) begin
      push_rd(0, 64'h6000 + 64'(i), (i == 3), 1'b0);
      r_beat(0, 64'h6000 + 64'(i), 2'b00, (i == 3));
    end
    step(); step();

    chk("ar_queue_drained", 64'(exp_ar.size()), 64'd0);
    chk("aw_queue_drained", 64'(exp_aw.size()), 64'd0);
    chk("w_queue_drained", 64'(exp_w.size()), 64'd0);
    chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
